// File: rtl/eater_bus_ctrl_if.sv
// Request/strobe interface of the bus-transfer sequencer.
//   master : the sequencer itself (takes requests, drives strobes)
//   slave  : the decoder/register-file side (issues requests, observes strobes)
// Signals:
//   req_valid/req_ready      request handshake
//   req_src/req_dst/req_imm  transfer description (src==NREG selects the immediate)
//   oe/we                    one-hot register output / write enables
//   imm_oe/imm_out           immediate bus drive and its captured value
//   busy/err/err_clr         status, sticky error flag and its clear
interface eater_bus_ctrl_if #(
  parameter int NREG = 4,
  parameter int W    = 8
);
  localparam int SELW = $clog2(NREG + 1);

  logic            req_valid;
  logic            req_ready;
  logic [SELW-1:0] req_src;
  logic [SELW-1:0] req_dst;
  logic [W-1:0]    req_imm;
  logic [NREG-1:0] oe;
  logic [NREG-1:0] we;
  logic            imm_oe;
  logic [W-1:0]    imm_out;
  logic            busy;
  logic            err;
  logic            err_clr;

  modport master (
    input  req_valid, req_src, req_dst, req_imm, err_clr,
    output req_ready, oe, we, imm_oe, imm_out, busy, err
  );

  modport slave (
    output req_valid, req_src, req_dst, req_imm, err_clr,
    input  req_ready, oe, we, imm_oe, imm_out, busy, err
  );
endinterface

// File: rtl/eater_bus_ctrl.sv
// Bus-transfer sequencer: moves one word per request from a source register
// (or an immediate) to a destination register, ordering the strobes so the
// bus settles before the write and is held one cycle after it.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    eater_bus_ctrl_if.master (request handshake, oe/we/imm strobes, status)
// Sequence per legal transfer accepted at edge k:
//   DRIVE for SETTLE cycles (source enable only), WRITE for 1 cycle (we[dst]),
//   HOLD for 1 cycle (source enable only), then IDLE.
module eater_bus_ctrl #(
  parameter int NREG   = 4,
  parameter int W      = 8,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  eater_bus_ctrl_if.master     bus
);
  localparam int SELW = $clog2(NREG + 1);
  localparam int CNTW = 3;

  typedef enum logic [1:0] {IDLE, DRIVE, WRITE, HOLD} state_e;

  state_e          state_q, state_d;
  logic [SELW-1:0] src_q, src_d;
  logic [SELW-1:0] dst_q, dst_d;
  logic [W-1:0]    imm_q, imm_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NREG-1:0] oe_q, oe_d;
  logic [NREG-1:0] we_q, we_d;
  logic            imm_oe_q, imm_oe_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic accept;
  logic illegal;

  assign accept  = bus.req_valid && (state_q == IDLE);

  // Equal indices are only illegal for two registers; src==dst==NREG is
  // already rejected by the destination range check.
  assign illegal = (bus.req_dst >= SELW'(NREG)) ||
                   (bus.req_src >  SELW'(NREG)) ||
                   (bus.req_src == bus.req_dst);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    imm_d   = imm_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // Clear first so a same-edge illegal accept below overrides it.
    if (bus.err_clr) err_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          src_d = bus.req_src;
          dst_d = bus.req_dst;
          imm_d = bus.req_imm;
          cnt_d = '0;
          if (illegal) err_d   = 1'b1;
          else         state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == CNTW'(SETTLE - 1)) state_d = WRITE;
        else                            cnt_d   = cnt_q + CNTW'(1);
      end
      WRITE:   state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Strobes are registered, so they are decoded from the next state and
    // the next captured indices; they then change exactly on the edge that
    // changes the state.
    oe_d     = '0;
    we_d     = '0;
    imm_oe_d = 1'b0;
    if (state_d != IDLE) begin
      imm_oe_d = (src_d == SELW'(NREG));
      for (int i = 0; i < NREG; i++) oe_d[i] = (src_d == SELW'(i));
    end
    if (state_d == WRITE) begin
      for (int i = 0; i < NREG; i++) we_d[i] = (dst_d == SELW'(i));
    end
    busy_d = (state_d != IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      imm_q    <= '0;
      cnt_q    <= '0;
      oe_q     <= '0;
      we_q     <= '0;
      imm_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      imm_q    <= imm_d;
      cnt_q    <= cnt_d;
      oe_q     <= oe_d;
      we_q     <= we_d;
      imm_oe_q <= imm_oe_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.oe        = oe_q;
  assign bus.we        = we_q;
  assign bus.imm_oe    = imm_oe_q;
  assign bus.imm_out   = imm_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_eater_bus_ctrl.sv
module tb_eater_bus_ctrl;
  localparam int S0 = 1;
  localparam int S1 = 3;

  typedef struct {
    logic [3:0] oe;
    logic       imm_oe;
    logic [7:0] imm;
    logic [3:0] we;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  eater_bus_ctrl_if #(.NREG(4), .W(8)) bus0 ();
  eater_bus_ctrl_if #(.NREG(4), .W(8)) bus1 ();

  eater_bus_ctrl #(.NREG(4), .W(8), .SETTLE(S0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  eater_bus_ctrl #(.NREG(4), .W(8), .SETTLE(S1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected strobe pattern of one legal transfer, one entry per busy cycle.
  task automatic push(input int id, input logic [2:0] s, input logic [2:0] d, input logic [7:0] imm);
    int   st;
    exp_t e;
    st = (id == 0) ? S0 : S1;
    for (int c = 0; c < st + 2; c++) begin
      e.oe     = (s < 3'd4) ? 4'(1 << s) : 4'b0000;
      e.imm_oe = (s == 3'd4);
      e.imm    = imm;
      e.we     = (c == st) ? 4'(1 << d) : 4'b0000;
      if (id == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
  endtask

  task automatic mon(input int id, input logic [3:0] oe, input logic imm_oe,
                     input logic [7:0] imm, input logic [3:0] we);
    exp_t e;
    bit   empty;
    string p;
    p = (id == 0) ? "d0" : "d1";
    if (oe != 4'b0 || imm_oe || we != 4'b0) begin
      empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        check({p, "_stray_strobe"}, {23'b0, oe, imm_oe, we}, 32'h0);
      end else begin
        e = (id == 0) ? q0.pop_front() : q1.pop_front();
        check({p, "_oe"},     {28'b0, oe}, {28'b0, e.oe});
        check({p, "_imm_oe"}, {31'b0, imm_oe}, {31'b0, e.imm_oe});
        check({p, "_we"},     {28'b0, we}, {28'b0, e.we});
        if (e.imm_oe) check({p, "_imm_out"}, {24'b0, imm}, {24'b0, e.imm});
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, bus0.oe, bus0.imm_oe, bus0.imm_out, bus0.we);
      mon(1, bus1.oe, bus1.imm_oe, bus1.imm_out, bus1.we);
    end
  end

  function automatic logic rdy(input int id);
    return (id == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  task automatic drive(input int id, input logic v, input logic [2:0] s,
                       input logic [2:0] d, input logic [7:0] imm);
    if (id == 0) begin
      bus0.req_valid = v; bus0.req_src = s; bus0.req_dst = d; bus0.req_imm = imm;
    end else begin
      bus1.req_valid = v; bus1.req_src = s; bus1.req_dst = d; bus1.req_imm = imm;
    end
  endtask

  // Called at a negedge; returns at the first negedge after the accept edge.
  task automatic send(input int id, input logic [2:0] s, input logic [2:0] d,
                      input logic [7:0] imm, input bit legal, input bit keep,
                      output int acc_cyc);
    int n;
    drive(id, 1'b1, s, d, imm);
    n = 0;
    while (!rdy(id) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", {31'b0, rdy(id)}, 32'h1);
    acc_cyc = cyc;
    @(posedge clk);
    if (legal) push(id, s, d, imm);
    @(negedge clk);
    if (!keep) drive(id, 1'b0, 3'd0, 3'd0, 8'h00);
  endtask

  // Counts negedges (the first one after accept counts as 1) until ready.
  task automatic wait_ready(input int id, output int n);
    n = 1;
    while (!rdy(id) && n < 50) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, n;
    rst_n = 1'b0;
    drive(0, 1'b0, 3'd0, 3'd0, 8'h00);
    drive(1, 1'b0, 3'd0, 3'd0, 8'h00);
    bus0.err_clr = 1'b0;
    bus1.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset values
    check("rst_ready",   {31'b0, bus0.req_ready}, 32'h1);
    check("rst_oe",      {28'b0, bus0.oe}, 32'h0);
    check("rst_we",      {28'b0, bus0.we}, 32'h0);
    check("rst_imm_oe",  {31'b0, bus0.imm_oe}, 32'h0);
    check("rst_imm_out", {24'b0, bus0.imm_out}, 32'h0);
    check("rst_busy",    {31'b0, bus0.busy}, 32'h0);
    check("rst_err",     {31'b0, bus0.err}, 32'h0);

    // Register to register: r0 -> r1
    send(0, 3'd0, 3'd1, 8'h00, 1'b1, 1'b0, a0);
    check("busy_during", {31'b0, bus0.busy}, 32'h1);
    wait_ready(0, n);
    check("ready_delay_s1", n, S0 + 3);
    check("busy_after", {31'b0, bus0.busy}, 32'h0);
    @(negedge clk);

    // Immediate A5 -> r3
    send(0, 3'd4, 3'd3, 8'hA5, 1'b1, 1'b0, a0);
    wait_ready(0, n);
    check("imm_ready_delay", n, S0 + 3);
    @(negedge clk);

    // Back-to-back with req_valid held: r0 -> r2, then r2 -> r1
    send(0, 3'd0, 3'd2, 8'h00, 1'b1, 1'b1, a0);
    send(0, 3'd2, 3'd1, 8'h00, 1'b1, 1'b0, a1);
    check("b2b_spacing", a1 - a0, S0 + 3);
    wait_ready(0, n);
    @(negedge clk);

    // Illegal: src == dst register
    send(0, 3'd2, 3'd2, 8'h00, 1'b0, 1'b0, a0);
    check("ill1_err",   {31'b0, bus0.err}, 32'h1);
    check("ill1_ready", {31'b0, bus0.req_ready}, 32'h1);
    check("ill1_busy",  {31'b0, bus0.busy}, 32'h0);
    bus0.err_clr = 1'b1;
    @(negedge clk);
    bus0.err_clr = 1'b0;
    check("errclr", {31'b0, bus0.err}, 32'h0);

    // Illegal dst=5 together with err_clr: set wins
    bus0.err_clr = 1'b1;
    send(0, 3'd0, 3'd5, 8'h00, 1'b0, 1'b0, a0);
    bus0.err_clr = 1'b0;
    check("ill2_err_set_wins", {31'b0, bus0.err}, 32'h1);
    check("ill2_ready", {31'b0, bus0.req_ready}, 32'h1);

    // err stays sticky over a legal transfer, then clear
    send(0, 3'd1, 3'd0, 8'h00, 1'b1, 1'b0, a0);
    wait_ready(0, n);
    check("err_sticky", {31'b0, bus0.err}, 32'h1);
    bus0.err_clr = 1'b1;
    @(negedge clk);
    bus0.err_clr = 1'b0;
    check("errclr2", {31'b0, bus0.err}, 32'h0);

    // Illegal src=5 (beyond the immediate selector)
    send(0, 3'd5, 3'd1, 8'h00, 1'b0, 1'b0, a0);
    check("ill3_err", {31'b0, bus0.err}, 32'h1);
    bus0.err_clr = 1'b1;
    @(negedge clk);
    bus0.err_clr = 1'b0;

    // SETTLE=3 instance: register then immediate
    send(1, 3'd1, 3'd0, 8'h00, 1'b1, 1'b0, a0);
    wait_ready(1, n);
    check("ready_delay_s3", n, S1 + 3);
    @(negedge clk);
    send(1, 3'd4, 3'd2, 8'h3C, 1'b1, 1'b0, a0);
    wait_ready(1, n);
    check("imm_ready_delay_s3", n, S1 + 3);
    @(negedge clk);

    // Asynchronous reset while WRITE is active
    send(0, 3'd3, 3'd0, 8'h00, 1'b1, 1'b0, a0);
    n = 0;
    while (bus0.we == 4'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("write_reached", {28'b0, bus0.we}, 32'h1);
    #1 rst_n = 1'b0;
    q0.delete();
    #1;
    check("arst_oe", {28'b0, bus0.oe}, 32'h0);
    check("arst_we", {28'b0, bus0.we}, 32'h0);
    check("arst_busy", {31'b0, bus0.busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_ready", {31'b0, bus0.req_ready}, 32'h1);
    check("arst_err", {31'b0, bus0.err}, 32'h0);
    repeat (3) @(negedge clk);
    check("post_rst_oe", {28'b0, bus0.oe}, 32'h0);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
